// File: rtl/mem_wb_stage_if.sv
// MEM -> MEM/WB stage bus: retiring-instruction handshake plus data-memory load response.
interface mem_wb_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [2:0]  in_funct3;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output in_valid, in_rd, in_reg_write, in_wb_sel, in_alu_result, in_pc_plus4,
           in_funct3, dmem_rvalid, dmem_rdata,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_reg_write, in_wb_sel, in_alu_result, in_pc_plus4,
           in_funct3, dmem_rvalid, dmem_rdata,
    output in_ready
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: captures one retiring instruction, waits for load data, aligns/extends it,
// and drives the register-file write port for exactly one cycle per commit.
module mem_wb_stage #(
  parameter int CNT_W        = 64,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  mem_wb_stage_if.slave    bus,
  output logic [4:0]       writeReg,
  output logic [31:0]      writeData,
  output logic             regWrite,
  output logic [CNT_W-1:0] instret,
  output logic             load_timeout
);
  localparam int TO_W = (LOAD_TIMEOUT < 256) ? 8 : $clog2(LOAD_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = (LOAD_TIMEOUT == 0) ? '0 : TO_W'(LOAD_TIMEOUT - 1);

  typedef enum logic [1:0] {EMPTY, WAIT_LOAD, COMMIT} state_e;

  state_e           state_q, state_d;
  logic [4:0]       rd_q, rd_d, wreg_q, wreg_d;
  logic             rw_q, rw_d, rwr_q, rwr_d, to_q, to_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      wdata_q, wdata_d, load_data;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             transfer, inc;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  assign bus.in_ready = (state_q == EMPTY) | (state_q == COMMIT);
  assign transfer     = bus.in_valid & bus.in_ready;

  // Load data is a naturally aligned word; pick the lane by the latched address bits.
  assign byte_sel = bus.dmem_rdata[{off_q, 3'b000} +: 8];
  assign half_sel = off_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'b0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'b0, half_sel};
      default: load_data = bus.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    f3_d    = f3_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    rwr_d   = 1'b0;
    to_d    = to_q;
    inc     = 1'b0;
    case (state_q)
      WAIT_LOAD: begin
        // A response arriving on the limit cycle still commits.
        if (bus.dmem_rvalid) begin
          wreg_d  = rd_q;
          wdata_d = load_data;
          rwr_d   = rw_q & (rd_q != 5'd0);
          inc     = 1'b1;
          state_d = COMMIT;
        end else if (LOAD_TIMEOUT != 0 && cnt_q == TO_LAST) begin
          to_d    = 1'b1;
          state_d = EMPTY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
        if (transfer) begin
          if (bus.in_wb_sel == 2'b01) begin
            rd_d    = bus.in_rd;
            rw_d    = bus.in_reg_write;
            f3_d    = bus.in_funct3;
            off_d   = bus.in_alu_result[1:0];
            cnt_d   = '0;
            state_d = WAIT_LOAD;
          end else begin
            wreg_d  = bus.in_rd;
            wdata_d = (bus.in_wb_sel == 2'b10) ? bus.in_pc_plus4 : bus.in_alu_result;
            rwr_d   = bus.in_reg_write & (bus.in_rd != 5'd0);
            inc     = 1'b1;
            state_d = COMMIT;
          end
        end
      end
    endcase
    instret_d = instret_q + CNT_W'(inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      rwr_q     <= 1'b0;
      to_q      <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      cnt_q     <= cnt_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      rwr_q     <= rwr_d;
      to_q      <= to_d;
      instret_q <= instret_d;
    end
  end

  assign writeReg     = wreg_q;
  assign writeData    = wdata_q;
  assign regWrite     = rwr_q;
  assign instret      = instret_q;
  assign load_timeout = to_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected commits queued at acceptance, checked when instret moves.
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        regWrite;
  logic [63:0] instret;
  logic        load_timeout;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] prev_instret = '0;
  logic [37:0] sb[$];  // {regWrite, rd, data}

  mem_wb_stage_if bus ();

  mem_wb_stage #(.CNT_W(64), .LOAD_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .writeReg(writeReg), .writeData(writeData),
    .regWrite(regWrite), .instret(instret), .load_timeout(load_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Every instret step must match the oldest queued commit.
  always @(negedge clk) begin
    if (rst) prev_instret = instret;
    else if (instret !== prev_instret) begin
      chk("instret_step", instret, prev_instret + 64'd1);
      if (sb.size() == 0) chk("unexpected_commit", 64'd1, 64'd0);
      else begin
        logic [37:0] e;
        e = sb.pop_front();
        chk("regWrite", {63'd0, regWrite}, {63'd0, e[37]});
        chk("writeReg", {59'd0, writeReg}, {59'd0, e[36:32]});
        chk("writeData", {32'd0, writeData}, {32'd0, e[31:0]});
      end
      prev_instret = instret;
    end
  end

  task automatic drive_fields(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                              input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
    bus.in_rd = rd; bus.in_reg_write = rw; bus.in_wb_sel = sel;
    bus.in_alu_result = alu; bus.in_pc_plus4 = pc4; bus.in_funct3 = f3;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic issue(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3,
                       input logic push, input logic [31:0] exp_data);
    int n;
    n = 0;
    drive_fields(rd, rw, sel, alu, pc4, f3);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("issue_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) sb.push_back({rw & (rd != 5'd0), rd, exp_data});
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic rvalid_pulse(input logic [31:0] data);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = data;
    @(posedge clk);
    #1 bus.dmem_rvalid = 1'b0;
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] rdata, input logic [31:0] exp_data);
    issue(rd, 1'b1, 2'b01, {30'h100, off}, 32'd0, f3, 1'b1, exp_data);
    repeat (2) @(posedge clk);
    #1 rvalid_pulse(rdata);
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    drive_fields(5'd0, 1'b0, 2'b00, 32'd0, 32'd0, 3'd0);
    @(posedge clk); @(negedge clk);
    chk("rst_regWrite", {63'd0, regWrite}, 64'd0);
    chk("rst_writeReg", {59'd0, writeReg}, 64'd0);
    chk("rst_writeData", {32'd0, writeData}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_timeout", {63'd0, load_timeout}, 64'd0);
    chk("rst_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Test 1: single ALU op
    issue(5'd5, 1'b1, 2'b00, 32'h1234, 32'h0, 3'd0, 1'b1, 32'h1234);
    @(negedge clk);
    chk("t1_regWrite", {63'd0, regWrite}, 64'd1);
    chk("t1_instret", instret, 64'd1);
    @(negedge clk);
    chk("t1_pulse_once", {63'd0, regWrite}, 64'd0);

    // Stray response while idle is ignored
    @(posedge clk); #1 rvalid_pulse(32'hDEAD_BEEF);
    @(negedge clk);
    chk("idle_rvalid_instret", instret, 64'd1);

    // Test 2: load alignment / extension
    do_load(5'd6, 3'b000, 2'd2, 32'h0080FF00, 32'hFFFFFF80);
    do_load(5'd7, 3'b100, 2'd2, 32'h0080FF00, 32'h00000080);
    do_load(5'd8, 3'b001, 2'd2, 32'h0080FF00, 32'h00000080);
    do_load(5'd9, 3'b101, 2'd0, 32'h0080FF00, 32'h0000FF00);
    do_load(5'd10, 3'b001, 2'd1, 32'h0080FF00, 32'hFFFFFF00);
    do_load(5'd11, 3'b000, 2'd1, 32'h0080FF00, 32'hFFFFFFFF);
    do_load(5'd12, 3'b010, 2'd3, 32'h0080FF00, 32'h0080FF00);
    chk("t2_instret", instret, 64'd8);

    // Test 3: four back-to-back ALU ops with in_valid held
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    drive_fields(5'd1, 1'b1, 2'b00, 32'h11, 32'h0, 3'd0);
    @(posedge clk);
    sb.push_back({1'b1, 5'd1, 32'h11});
    for (int i = 2; i <= 4; i++) begin
      #1 drive_fields(5'(i), 1'b1, (i == 4) ? 2'b11 : 2'b00, 32'(i * 16 + i), 32'h0, 3'd0);
      @(negedge clk);
      chk("t3_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("t3_pulse", {63'd0, regWrite}, 64'd1);
      @(posedge clk);
      sb.push_back({1'b1, 5'(i), 32'(i * 16 + i)});
    end
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t3_pulse_last", {63'd0, regWrite}, 64'd1);
    chk("t3_instret", instret, 64'd12);

    // Test 4: rd=0 counts but never writes; JAL selects PC+4
    @(posedge clk); #1;
    issue(5'd0, 1'b1, 2'b00, 32'h55, 32'h0, 3'd0, 1'b1, 32'h55);
    @(negedge clk);
    chk("t4_rd0_nowrite", {63'd0, regWrite}, 64'd0);
    @(posedge clk); #1;
    issue(5'd1, 1'b1, 2'b10, 32'h999, 32'h104, 3'd0, 1'b1, 32'h104);
    @(negedge clk);
    chk("t4_instret", instret, 64'd14);

    // Test 5: load timeout with LOAD_TIMEOUT=4
    @(posedge clk); #1;
    issue(5'd3, 1'b1, 2'b01, 32'h200, 32'h0, 3'b010, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_ready_low", {63'd0, bus.in_ready}, 64'd0);
    end
    @(negedge clk);
    chk("t5_ready_back", {63'd0, bus.in_ready}, 64'd1);
    chk("t5_flag", {63'd0, load_timeout}, 64'd1);
    chk("t5_instret", instret, 64'd14);
    @(posedge clk); #1 rvalid_pulse(32'h1111_2222);
    @(negedge clk);
    chk("t5_late_nowrite", {63'd0, regWrite}, 64'd0);
    chk("t5_flag_sticky", {63'd0, load_timeout}, 64'd1);

    // Test 6: reset while waiting for load data
    @(posedge clk); #1;
    issue(5'd4, 1'b1, 2'b01, 32'h300, 32'h0, 3'b010, 1'b0, 32'h0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t6_regWrite", {63'd0, regWrite}, 64'd0);
    chk("t6_writeReg", {59'd0, writeReg}, 64'd0);
    chk("t6_writeData", {32'd0, writeData}, 64'd0);
    chk("t6_instret", instret, 64'd0);
    chk("t6_flag", {63'd0, load_timeout}, 64'd0);
    chk("t6_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    rvalid_pulse(32'hCAFE_F00D);
    @(negedge clk);
    chk("t6_no_write", {63'd0, regWrite}, 64'd0);
    @(negedge clk);
    chk("t6_instret_hold", instret, 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
